// File: rtl/repl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | repl_pkg : shared types and constants for the instruction REPL     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package repl_pkg;

  localparam int          REGFILE_BITS         = 1024;
  localparam int          REGFILE_BYTES        = 128;
  localparam int          BYTE_IDX_W           = $clog2(REGFILE_BYTES);
  localparam int          DRAIN_CYCLES_DEFAULT = 5;
  localparam logic [31:0] NOP_INST             = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_RECV  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SNAP  = 3'd3,
    ST_SEND  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_serializer : holds a register-file snapshot and streams it |
// | out byte 0 first over a valid/ready port.  Revision : 1.0          |
// +--------------------------------------------------------------------+
module regfile_serializer
  import repl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [REGFILE_BITS-1:0] snap_in,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  output logic                    done
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(REGFILE_BYTES - 1);

  logic [REGFILE_BITS-1:0] snapshot;
  logic [BYTE_IDX_W-1:0]   idx;
  logic                    valid;
  logic                    accept;

  assign accept = valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= '0;
      idx      <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      snapshot <= snap_in;
      idx      <= '0;
      valid    <= 1'b1;
    end else if (accept) begin
      // Index wraps to 0 naturally after the last byte.
      idx <= idx + 1'b1;
      if (idx == LAST_IDX) valid <= 1'b0;
    end
  end

  assign tx_data  = snapshot[{idx, 3'b000} +: 8];
  assign tx_valid = valid;
  assign done     = accept && (idx == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/repl_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | repl_sequencer : UART-fed instruction injector that dumps the CPU  |
// | register file after each instruction.  Revision : 1.0             |
// +--------------------------------------------------------------------+
module repl_sequencer #(
  parameter int          DRAIN_CYCLES = repl_pkg::DRAIN_CYCLES_DEFAULT,
  parameter logic [31:0] NOP_INST     = repl_pkg::NOP_INST
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic [7:0]                        tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic [31:0]                       inst_out,
  input  logic [repl_pkg::REGFILE_BITS-1:0] regfile_in,
  output logic                              busy,
  output logic                              overrun
);

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  repl_pkg::state_t state, state_next;
  logic [1:0]       byte_cnt;
  logic [31:0]      shift_buf;
  logic [DW-1:0]    drain_cnt;
  logic             snap_load;
  logic             send_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= repl_pkg::ST_RECV;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    inst_out   = NOP_INST;
    busy       = 1'b1;
    snap_load  = 1'b0;
    case (state)
      repl_pkg::ST_RECV: begin
        busy = 1'b0;
        if (rx_valid && byte_cnt == 2'd3) state_next = repl_pkg::ST_ISSUE;
      end
      repl_pkg::ST_ISSUE: begin
        inst_out   = shift_buf;
        state_next = repl_pkg::ST_DRAIN;
      end
      repl_pkg::ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_next = repl_pkg::ST_SNAP;
      end
      repl_pkg::ST_SNAP: begin
        snap_load  = 1'b1;
        state_next = repl_pkg::ST_SEND;
      end
      repl_pkg::ST_SEND: begin
        if (send_done) state_next = repl_pkg::ST_RECV;
      end
      default: state_next = repl_pkg::ST_RECV;
    endcase
  end

  // Bytes arriving outside RECV are dropped and flagged; nothing else moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      shift_buf <= '0;
      drain_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      if (rx_valid) begin
        if (state == repl_pkg::ST_RECV) begin
          shift_buf <= {rx_data, shift_buf[31:8]};
          byte_cnt  <= byte_cnt + 2'd1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (state == repl_pkg::ST_DRAIN)
        drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + DW'(1);
    end
  end

  regfile_serializer u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (snap_load),
    .snap_in  (regfile_in),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (send_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_repl_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_repl_sequencer : directed self-checking bench for repl_sequencer|
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_repl_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data, rx_data1;
  logic          rx_valid, rx_valid1;
  logic          tx_ready, tx_ready1;
  logic [1023:0] regfile;
  logic [1023:0] snap_exp;

  logic [7:0]  tx_data, tx_data1;
  logic        tx_valid, tx_valid1;
  logic [31:0] inst_out, inst_out1;
  logic        busy, busy1, overrun, overrun1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  rxb  [128];
  logic [7:0]  rxb1 [128];

  always #5 clk = ~clk;

  repl_sequencer dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .inst_out(inst_out), .regfile_in(regfile), .busy(busy), .overrun(overrun)
  );

  repl_sequencer #(.DRAIN_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .inst_out(inst_out1), .regfile_in(regfile), .busy(busy1), .overrun(overrun1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte1(input logic [7:0] b);
    @(negedge clk);
    rx_data1  = b;
    rx_valid1 = 1'b1;
    @(negedge clk);
    rx_valid1 = 1'b0;
  endtask

  // Little-endian: w[7:0] goes first; returns in the ISSUE cycle.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_tx(output int lat, output int extra);
    lat = 0;
    extra = 0;
    while (!tx_valid && lat < 50) begin
      @(negedge clk);
      lat++;
      if (inst_out !== NOP) extra++;
    end
  endtask

  task automatic collect(input int limit, input bit toggle, output int got_n, output int bad_stall);
    int k;
    bit stalled;
    logic [7:0] held;
    got_n = 0; bad_stall = 0; k = 0; stalled = 0; held = '0;
    while (got_n < limit && k < 2000) begin
      tx_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (stalled && tx_data !== held) bad_stall++;
      if (tx_valid && tx_ready) begin
        rxb[got_n] = tx_data;
        got_n++;
        stalled = 0;
      end else if (tx_valid) begin
        stalled = 1;
        held = tx_data;
      end
      k++;
      @(negedge clk);
    end
    tx_ready = 1'b0;
  endtask

  task automatic payload_check(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (rxb[i] !== snap_exp[8*i +: 8]) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    int lat, extra, n, bad, cnt;
    rst_n = 1'b0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    rx_data1 = '0; rx_valid1 = 1'b0; tx_ready1 = 1'b0;
    regfile = '0;
    snap_exp = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_inst", inst_out, NOP);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic word with x1 = 5
    regfile[63:32] = 32'h5;
    snap_exp = regfile;
    send_word(32'h0050_0093);
    check("issue_word", inst_out, 32'h0050_0093);
    check("busy_issue", busy, 1);
    wait_tx(lat, extra);
    check("latency", lat, 7);
    check("nop_after_issue", extra, 0);
    collect(128, 1'b0, n, bad);
    check("tx_count", n, 128);
    payload_check("payload1");
    check("byte4", 32'(rxb[4]), 32'h05);
    check("idle_tx_valid", tx_valid, 0);
    check("idle_busy", busy, 0);

    // Back-pressure 1-0-0-1
    send_word(32'h0050_0093);
    wait_tx(lat, extra);
    collect(128, 1'b1, n, bad);
    check("bp_count", n, 128);
    check("bp_stall_stable", bad, 0);
    payload_check("payload_bp");

    // Overrun during DRAIN, snapshot isolation
    regfile[1023:992] = 32'hDEAD_BEEF;
    snap_exp = regfile;
    send_word(32'h0010_0513);
    send_byte(8'hAA);
    check("overrun_set", overrun, 1);
    wait_tx(lat, extra);
    regfile = '1;
    collect(128, 1'b0, n, bad);
    regfile = snap_exp;
    payload_check("payload_snap");
    check("byte124", 32'(rxb[124]), 32'hEF);
    send_word(32'h0000_40B7);
    check("post_overrun_word", inst_out, 32'h0000_40B7);
    check("overrun_sticky", overrun, 1);
    wait_tx(lat, extra);

    // Reset after 60 bytes
    collect(60, 1'b0, n, bad);
    check("partial_count", n, 60);
    check("pre_rst_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_valid", tx_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_overrun", overrun, 0);
    check("rst_mid_inst", inst_out, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_valid) cnt++;
    end
    tx_ready = 1'b0;
    check("no_tx_after_rst", cnt, 0);

    // Reset mid-RECV discards the partial word
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_word(32'h0050_0093);
    check("word_after_recv_rst", inst_out, 32'h0050_0093);

    // DRAIN_CYCLES=1 build with 1000-cycle gaps between bytes
    for (int i = 0; i < 4; i++) begin
      repeat (1000) @(negedge clk);
      if (i == 3) begin
        check("gap_busy", busy1, 0);
        check("gap_inst", inst_out1, NOP);
      end
      case (i)
        0: send_byte1(8'h93);
        1: send_byte1(8'h00);
        2: send_byte1(8'h50);
        default: send_byte1(8'h00);
      endcase
    end
    check("d1_issue_word", inst_out1, 32'h0050_0093);
    lat = 0;
    while (!tx_valid1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("d1_latency", lat, 3);
    tx_ready1 = 1'b1;
    n = 0;
    repeat (200) begin
      if (tx_valid1 && n < 128) begin
        rxb1[n] = tx_data1;
        n++;
      end
      @(negedge clk);
    end
    tx_ready1 = 1'b0;
    check("d1_count", n, 128);
    check("d1_byte4", 32'(rxb1[4]), 32'h05);
    check("d1_byte127", 32'(rxb1[127]), 32'hDE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
